// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared definitions for the 5-stage RV32I/RV32E pipeline control logic.
//   - opcode constants: inst[6:2] values of the base integer opcodes
//   - FWD_* codes: operand select driven to the EX-stage operand muxes
//   - stage_t: one entry of the hazard unit's shadow pipeline
//   - src_hit / fwd_select: the per-stage match rule and the
//     youngest-producer-wins priority encoder
package pipe_pkg;

  localparam logic [4:0] I_LOAD     = 5'b00000;
  localparam logic [4:0] I_CAL      = 5'b00100;
  localparam logic [4:0] AUIPC_TYPE = 5'b00101;
  localparam logic [4:0] S_TYPE     = 5'b01000;
  localparam logic [4:0] R_TYPE     = 5'b01100;
  localparam logic [4:0] LUI_TYPE   = 5'b01101;
  localparam logic [4:0] B_TYPE     = 5'b11000;
  localparam logic [4:0] JALR_TYPE  = 5'b11001;
  localparam logic [4:0] JAL_TYPE   = 5'b11011;

  // operand select codes seen by the EX stage
  localparam logic [1:0] FWD_RF   = 2'd0;  // register file value
  localparam logic [1:0] FWD_MEM  = 2'd1;  // result currently in MEM
  localparam logic [1:0] FWD_WB   = 2'd2;  // result currently in WB
  localparam logic [1:0] FWD_HELD = 2'd3;  // WB value held after retirement

  // Register numbers are stored at full RV32I width; RV32E configurations
  // zero-extend so both share one entry layout.
  localparam int RD_W = 5;

  typedef struct packed {
    logic            v;
    logic [RD_W-1:0] rd;
    logic            we;
    logic            ld;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '{v: 1'b0, rd: '0, we: 1'b0, ld: 1'b0};

  // A source depends on a stage only if it is actually read, the stage holds
  // a real register writer, and the register is not x0.
  function automatic logic src_hit(input logic re, input logic [RD_W-1:0] rs,
                                   input stage_t s);
    return re && s.v && s.we && (s.rd == rs) && (rs != '0);
  endfunction

  // hit[0] = EX, hit[1] = MEM, hit[2] = WB; the youngest producer is the
  // architecturally correct value when several stages write the same rd.
  function automatic logic [1:0] fwd_select(input logic [2:0] hit,
                                            input logic wb_bypass);
    logic [1:0] code;
    code = FWD_RF;
    if (hit[0])      code = FWD_MEM;
    else if (hit[1]) code = FWD_WB;
    else if (hit[2]) code = wb_bypass ? FWD_RF : FWD_HELD;
    return code;
  endfunction

endpackage

// File: rtl/inst_reg_decode.sv
// inst_reg_decode
//   Combinational register-usage decode of the instruction in ID.
//   Ports:
//     inst       in   32      instruction word
//     rs1, rs2   out  REG_AW  source register fields inst[15+:], inst[20+:]
//     rd         out  REG_AW  destination field inst[7+:]
//     re1, re2   out  1       source register actually read
//     we         out  1       instruction writes rd
//     ld         out  1       instruction is a load (result late in MEM)
//   Register fields are passed through unconditionally; only the enables
//   depend on the opcode. Anything that is not a 32-bit encoding
//   (inst[1:0] != 2'b11) or not a known opcode reads and writes nothing.
module inst_reg_decode
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [31:0]       inst,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [REG_AW-1:0] rd,
  output logic              re1,
  output logic              re2,
  output logic              we,
  output logic              ld
);

  assign rs1 = inst[15 +: REG_AW];
  assign rs2 = inst[20 +: REG_AW];
  assign rd  = inst[7 +: REG_AW];

  always_comb begin
    re1 = 1'b0;
    re2 = 1'b0;
    we  = 1'b0;
    ld  = 1'b0;
    if (inst[1:0] == 2'b11) begin
      case (inst[6:2])
        R_TYPE: begin
          re1 = 1'b1;
          re2 = 1'b1;
          we  = 1'b1;
        end
        I_CAL: begin
          re1 = 1'b1;
          we  = 1'b1;
        end
        I_LOAD: begin
          re1 = 1'b1;
          we  = 1'b1;
          ld  = 1'b1;
        end
        S_TYPE, B_TYPE: begin
          re1 = 1'b1;
          re2 = 1'b1;
        end
        LUI_TYPE, AUIPC_TYPE, JAL_TYPE: begin
          we = 1'b1;
        end
        JALR_TYPE: begin
          re1 = 1'b1;
          we  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   Register hazard unit between ID and the ID/EX register of the 5-stage
//   RV32I/RV32E pipeline. Keeps a shadow copy of the destination writes of
//   the instructions in EX, MEM and WB, requests a one-cycle stall on a
//   load-use dependency, and registers the operand forward selects that the
//   datapath applies once the ID instruction reaches EX.
//   Parameters:
//     REG_AW     register address width (5 = RV32I, 4 = RV32E)
//     WB_BYPASS  1 = register file writes through, WB producers need no forward
//     HAZARD_EN  0 = stall tied low, forwarding unaffected
//   Ports:
//     clk, rst_n           clock; synchronous active-low reset
//     id_inst, id_valid    instruction in ID and its valid flag
//     hold                 global freeze, all state held
//     flush                redirect from EX, kills the ID instruction
//     rs1, rs2, re1, re2   decoded sources of the ID instruction (comb)
//     stall                load-use stall request (comb)
//     ex_fwd_a, ex_fwd_b   registered operand selects for the EX instruction
//     ex_valid             EX holds a real instruction
module hazard_forward_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int WB_BYPASS = 1,
  parameter int HAZARD_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       id_inst,
  input  logic              id_valid,
  input  logic              hold,
  input  logic              flush,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic              re1,
  output logic              re2,
  output logic              stall,
  output logic [1:0]        ex_fwd_a,
  output logic [1:0]        ex_fwd_b,
  output logic              ex_valid
);

  localparam logic HZ_ON  = (HAZARD_EN != 0);
  localparam logic BYP_ON = (WB_BYPASS != 0);

  logic [REG_AW-1:0] id_rd;
  logic              id_we;
  logic              id_ld;

  inst_reg_decode #(
    .REG_AW (REG_AW)
  ) u_decode (
    .inst (id_inst),
    .rs1  (rs1),
    .rs2  (rs2),
    .rd   (id_rd),
    .re1  (re1),
    .re2  (re2),
    .we   (id_we),
    .ld   (id_ld)
  );

  // shadow pipeline: s0 = EX, s1 = MEM, s2 = WB
  stage_t s0, s1, s2;

  logic [RD_W-1:0] rs1_x, rs2_x, rd_x;
  logic [2:0]      hit_a, hit_b;
  logic            load_use;
  logic            issue;
  logic [1:0]      fwd_a_nxt, fwd_b_nxt;
  stage_t          id_entry;

  always_comb begin
    rs1_x = '0;
    rs2_x = '0;
    rd_x  = '0;
    rs1_x[REG_AW-1:0] = rs1;
    rs2_x[REG_AW-1:0] = rs2;
    rd_x[REG_AW-1:0]  = id_rd;
  end

  always_comb begin
    hit_a[0] = src_hit(re1, rs1_x, s0);
    hit_a[1] = src_hit(re1, rs1_x, s1);
    hit_a[2] = src_hit(re1, rs1_x, s2);
    hit_b[0] = src_hit(re2, rs2_x, s0);
    hit_b[1] = src_hit(re2, rs2_x, s1);
    hit_b[2] = src_hit(re2, rs2_x, s2);
  end

  // A load in EX has no result until the end of MEM, so a consumer directly
  // behind it must wait one cycle; afterwards the load sits in MEM and the
  // normal WB-result forward covers it.
  assign load_use = (hit_a[0] || hit_b[0]) && s0.ld;

  // flush wins over stall: the killed instruction must not hold up ID
  assign stall = HZ_ON && id_valid && !flush && load_use;
  assign issue = id_valid && !stall && !flush;

  // hit vectors already include re, so a source that is not read gets 0
  assign fwd_a_nxt = fwd_select(hit_a, BYP_ON);
  assign fwd_b_nxt = fwd_select(hit_b, BYP_ON);

  assign id_entry = '{v: 1'b1, rd: rd_x, we: id_we, ld: id_ld};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0       <= STAGE_BUBBLE;
      s1       <= STAGE_BUBBLE;
      s2       <= STAGE_BUBBLE;
      ex_fwd_a <= FWD_RF;
      ex_fwd_b <= FWD_RF;
      ex_valid <= 1'b0;
    end else if (!hold) begin
      s2       <= s1;
      s1       <= s0;
      s0       <= issue ? id_entry : STAGE_BUBBLE;
      ex_fwd_a <= issue ? fwd_a_nxt : FWD_RF;
      ex_fwd_b <= issue ? fwd_b_nxt : FWD_RF;
      ex_valid <= issue;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] id_inst = 32'h0;
  logic        id_valid = 1'b0;
  logic        hold = 1'b0;
  logic        flush = 1'b0;

  logic [4:0] d0_rs1, d0_rs2;
  logic       d0_re1, d0_re2, d0_stall, d0_ev;
  logic [1:0] d0_fa, d0_fb;
  logic [3:0] d1_rs1, d1_rs2;
  logic       d1_re1, d1_re2, d1_stall, d1_ev;
  logic [1:0] d1_fa, d1_fb;

  always #5 clk = ~clk;

  hazard_forward_unit dut0 (
    .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .id_valid(id_valid),
    .hold(hold), .flush(flush), .rs1(d0_rs1), .rs2(d0_rs2), .re1(d0_re1),
    .re2(d0_re2), .stall(d0_stall), .ex_fwd_a(d0_fa), .ex_fwd_b(d0_fb),
    .ex_valid(d0_ev)
  );

  hazard_forward_unit #(.REG_AW(4), .WB_BYPASS(0), .HAZARD_EN(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .id_valid(id_valid),
    .hold(hold), .flush(flush), .rs1(d1_rs1), .rs2(d1_rs2), .re1(d1_re1),
    .re2(d1_re2), .stall(d1_stall), .ex_fwd_a(d1_fa), .ex_fwd_b(d1_fb),
    .ex_valid(d1_ev)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int p, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d @%0t: got %0h, want %0h", name, p, $time, act, exp);
  endtask

  // ---------------- reference model ----------------
  int AWP[2]  = '{5, 4};
  bit BYP[2]  = '{1'b1, 1'b0};
  bit HEN[2]  = '{1'b1, 1'b0};

  // in-flight writers, index 0 = youngest (EX), 2 = oldest (WB)
  bit mv[2][3], mw[2][3], ml[2][3];
  int mrd[2][3];
  int mfa[2], mfb[2];
  bit mev[2];
  bit nv[2][3], nw[2][3], nl[2][3];
  int nrd[2][3];
  int nfa[2], nfb[2];
  bit nev[2];
  bit chk_en = 1'b0;

  // register usage by instruction class
  function automatic void classify(input logic [31:0] i, output bit r1,
                                   output bit r2, output bit w, output bit l);
    r1 = 0; r2 = 0; w = 0; l = 0;
    if (i[1:0] == 2'b11) begin
      case (i[6:0])
        7'b0110011: begin r1 = 1; r2 = 1; w = 1; end         // OP
        7'b0010011: begin r1 = 1; w = 1; end                 // OP-IMM
        7'b0000011: begin r1 = 1; w = 1; l = 1; end          // LOAD
        7'b0100011, 7'b1100011: begin r1 = 1; r2 = 1; end    // STORE, BRANCH
        7'b0110111, 7'b0010111, 7'b1101111: w = 1;           // LUI, AUIPC, JAL
        7'b1100111: begin r1 = 1; w = 1; end                 // JALR
        default: ;
      endcase
    end
  endfunction

  function automatic int code_of(input bit [2:0] h, input bit byp);
    for (int k = 0; k < 3; k++)
      if (h[k]) return (k == 0) ? 1 : (k == 1) ? 2 : (byp ? 0 : 3);
    return 0;
  endfunction

  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      bit r1, r2, w, l, st, iss;
      bit [2:0] ha, hb;
      int mask, s1v, s2v, rdv, ca, cb;
      classify(id_inst, r1, r2, w, l);
      mask = (1 << AWP[p]) - 1;
      s1v = int'(id_inst >> 15) & mask;
      s2v = int'(id_inst >> 20) & mask;
      rdv = int'(id_inst >> 7) & mask;
      for (int k = 0; k < 3; k++) begin
        ha[k] = r1 && mv[p][k] && mw[p][k] && mrd[p][k] == s1v && s1v != 0;
        hb[k] = r2 && mv[p][k] && mw[p][k] && mrd[p][k] == s2v && s2v != 0;
      end
      st = HEN[p] && id_valid && !flush && (ha[0] || hb[0]) && ml[p][0];
      ca = code_of(ha, BYP[p]);
      cb = code_of(hb, BYP[p]);
      if (chk_en) begin
        chk("m_rs1", p, p == 0 ? 32'(d0_rs1) : 32'(d1_rs1), 32'(s1v));
        chk("m_rs2", p, p == 0 ? 32'(d0_rs2) : 32'(d1_rs2), 32'(s2v));
        chk("m_re1", p, p == 0 ? 32'(d0_re1) : 32'(d1_re1), 32'(r1));
        chk("m_re2", p, p == 0 ? 32'(d0_re2) : 32'(d1_re2), 32'(r2));
        chk("m_stall", p, p == 0 ? 32'(d0_stall) : 32'(d1_stall), 32'(st));
        chk("m_fwd_a", p, p == 0 ? 32'(d0_fa) : 32'(d1_fa), 32'(mfa[p]));
        chk("m_fwd_b", p, p == 0 ? 32'(d0_fb) : 32'(d1_fb), 32'(mfb[p]));
        chk("m_ex_valid", p, p == 0 ? 32'(d0_ev) : 32'(d1_ev), 32'(mev[p]));
      end
      for (int k = 0; k < 3; k++) begin
        nv[p][k] = mv[p][k]; nw[p][k] = mw[p][k];
        nl[p][k] = ml[p][k]; nrd[p][k] = mrd[p][k];
      end
      nfa[p] = mfa[p]; nfb[p] = mfb[p]; nev[p] = mev[p];
      if (!rst_n) begin
        for (int k = 0; k < 3; k++) nv[p][k] = 0;
        nfa[p] = 0; nfb[p] = 0; nev[p] = 0;
      end else if (!hold) begin
        iss = id_valid && !st && !flush;
        for (int k = 2; k > 0; k--) begin
          nv[p][k] = mv[p][k-1]; nw[p][k] = mw[p][k-1];
          nl[p][k] = ml[p][k-1]; nrd[p][k] = mrd[p][k-1];
        end
        nv[p][0] = iss; nw[p][0] = w; nl[p][0] = l; nrd[p][0] = rdv;
        nfa[p] = iss ? ca : 0;
        nfb[p] = iss ? cb : 0;
        nev[p] = iss;
      end
    end
  end

  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 3; k++) begin
        mv[p][k] = nv[p][k]; mw[p][k] = nw[p][k];
        ml[p][k] = nl[p][k]; mrd[p][k] = nrd[p][k];
      end
      mfa[p] = nfa[p]; mfb[p] = nfb[p]; mev[p] = nev[p];
    end
    if (!rst_n) chk_en = 1'b1;
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] enc_r(input int rd, input int a, input int b);
    return {7'b0, 5'(b), 5'(a), 3'b000, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_lw(input int rd, input int a);
    return {12'h0, 5'(a), 3'b010, 5'(rd), 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_lui(input int rd, input int imm);
    return {20'(imm), 5'(rd), 7'b0110111};
  endfunction

  task automatic cyc(input logic [31:0] inst, input logic v, input logic h = 1'b0,
                     input logic f = 1'b0, input logic r = 1'b1);
    @(posedge clk);
    #1;
    id_inst = inst; id_valid = v; hold = h; flush = f; rst_n = r;
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (3) cyc(32'h0, 1'b0);
  endtask

  logic [31:0] tmp;

  initial begin
    repeat (2) @(negedge clk);
    cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_ex_valid", 0, d0_ev, 0);
    chk("rst_fwd_a", 0, d0_fa, 0);

    // R-type dependency
    cyc(enc_r(5, 1, 2), 1'b1);
    chk("r_stall0", 0, d0_stall, 0);
    cyc(enc_r(6, 5, 3), 1'b1);
    chk("r_stall1", 0, d0_stall, 0);
    cyc(32'h0, 1'b0);
    chk("r_fwd_a", 0, d0_fa, 1);
    chk("r_fwd_b", 0, d0_fb, 0);
    chk("r_ex_valid", 0, d0_ev, 1);
    drain();

    // load-use
    cyc(enc_lw(7, 1), 1'b1);
    cyc(enc_r(8, 7, 7), 1'b1);
    chk("lu_stall", 0, d0_stall, 1);
    chk("lu_nostall_hen0", 1, d1_stall, 0);
    cyc(enc_r(8, 7, 7), 1'b1);
    chk("lu_stall_once", 0, d0_stall, 0);
    chk("lu_bubble", 0, d0_ev, 0);
    chk("lu_hen0_fwd_a", 1, d1_fa, 1);
    cyc(32'h0, 1'b0);
    chk("lu_ex_valid", 0, d0_ev, 1);
    chk("lu_fwd_a", 0, d0_fa, 2);
    chk("lu_fwd_b", 0, d0_fb, 2);
    drain();

    // x0 destination
    cyc(enc_lui(0, 1), 1'b1);
    cyc(enc_r(9, 0, 0), 1'b1);
    chk("x0_stall", 0, d0_stall, 0);
    cyc(32'h0, 1'b0);
    chk("x0_fwd_a", 0, d0_fa, 0);
    chk("x0_fwd_b", 0, d0_fb, 0);
    drain();

    // non-readers with rs fields naming a live producer
    cyc(enc_r(5, 1, 2), 1'b1);
    cyc({7'b0, 5'd6, 5'd5, 3'b000, 5'd1, 7'b1101111}, 1'b1);
    chk("jal_re1", 0, d0_re1, 0);
    chk("jal_re2", 0, d0_re2, 0);
    chk("jal_rs1_field", 0, d0_rs1, 5);
    cyc({7'b0, 5'd6, 5'd5, 3'b000, 5'd2, 7'b0110111}, 1'b1);
    chk("lui_re1", 0, d0_re1, 0);
    cyc(32'h0, 1'b0);
    chk("lui_fwd_a", 0, d0_fa, 0);
    chk("lui_fwd_b", 0, d0_fb, 0);
    drain();

    // WB distance
    cyc(enc_r(4, 1, 2), 1'b1);
    cyc(enc_r(10, 1, 2), 1'b1);
    cyc(enc_r(11, 1, 2), 1'b1);
    cyc(enc_r(12, 4, 4), 1'b1);
    cyc(32'h0, 1'b0);
    chk("wb_byp_fwd_a", 0, d0_fa, 0);
    chk("wb_held_fwd_a", 1, d1_fa, 3);
    chk("wb_held_fwd_b", 1, d1_fb, 3);
    drain();

    // flush during a load-use stall
    cyc(enc_lw(7, 1), 1'b1);
    cyc(enc_r(8, 7, 7), 1'b1, 1'b0, 1'b1);
    chk("fl_stall", 0, d0_stall, 0);
    cyc(32'h0, 1'b0);
    chk("fl_bubble", 0, d0_ev, 0);
    drain();

    // hold freezes outputs
    cyc(enc_r(5, 1, 2), 1'b1);
    cyc(enc_r(6, 5, 3), 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(enc_r(13, 5, 5), 1'b1, 1'b1);
      chk("hold_fwd_a", 0, d0_fa, 1);
      chk("hold_ex_valid", 0, d0_ev, 1);
    end
    cyc(32'h0, 1'b0);
    chk("hold_release", 0, d0_fa, 1);
    drain();

    // stall evaluated on frozen state
    cyc(enc_lw(7, 1), 1'b1);
    cyc(enc_r(8, 7, 7), 1'b1, 1'b1);
    chk("hold_stall0", 0, d0_stall, 1);
    cyc(enc_r(8, 7, 7), 1'b1, 1'b1);
    chk("hold_stall1", 0, d0_stall, 1);
    drain();

    // reset with a valid pipeline
    cyc(enc_r(5, 1, 2), 1'b1);
    cyc(enc_r(6, 5, 3), 1'b1);
    cyc(32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("pre_rst_ev", 0, d0_ev, 1);
    cyc(32'h0, 1'b0);
    chk("post_rst_ev", 0, d0_ev, 0);
    chk("post_rst_fa", 0, d0_fa, 0);

    // reset in the middle of a stall
    cyc(enc_lw(7, 1), 1'b1);
    cyc(enc_r(8, 7, 7), 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_stall", 0, d0_stall, 1);
    cyc(enc_r(8, 7, 7), 1'b1);
    chk("rst_clears_stall", 0, d0_stall, 0);
    drain();

    // illegal encodings never write
    tmp = enc_r(5, 1, 2);
    tmp[1:0] = 2'b01;
    cyc(tmp, 1'b1);
    chk("ill_re1", 0, d0_re1, 0);
    chk("ill_re2", 0, d0_re2, 0);
    tmp = enc_r(6, 1, 2);
    tmp[6:2] = 5'b11111;
    cyc(tmp, 1'b1);
    chk("ill_op_re1", 0, d0_re1, 0);
    cyc(enc_r(7, 5, 6), 1'b1);
    cyc(32'h0, 1'b0);
    chk("ill_fwd_a", 0, d0_fa, 0);
    chk("ill_fwd_b", 0, d0_fb, 0);
    drain();

    // randomized traffic, checked every cycle by the model
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] ins;
      logic [6:0] ops[11];
      int sel;
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
              7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0110001,
              7'b1111111};
      sel = $urandom_range(0, 10);
      ins = $urandom;
      ins[6:0] = ops[sel];
      if (sel == 2) ins[6:0] = 7'b0000011;
      if ($urandom_range(0, 9) < 8) begin
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
      end
      cyc(ins, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 10,
          $urandom_range(0, 99) < 8, $urandom_range(0, 99) >= 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

- **Role:** Parametrised register-hazard unit for the 5-stage RV32I/RV32E pipeline. It sits between the ID stage and the ID/EX pipeline register.
- **ID-stage decode:** Decodes source-register usage of the instruction in ID (rs1/rs2 plus read enables).
- **Producer tracking:** Tracks destination writes of the three younger-to-older in-flight stages (EX, MEM, WB) in an internal shadow pipeline.
- **Outputs:** Generates the load-use stall, and registered forwarding selects that the datapath applies to the instruction in EX.

## Interface
Parameters:
- REG_AW, 5, register address width (5 = RV32I, 4 = RV32E; instruction bits above REG_AW ignored)
- WB_BYPASS, 1, 1 = register file writes through same cycle so WB producers need no forward; 0 = WB producers select code 3
- HAZARD_EN, 1, 0 = stall output forced 0 (forwarding still active)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock, synchronous, active-low
- id_inst  in  32  instruction in ID
- id_valid  in  1  ID holds a real instruction
- hold  in  1  global pipeline freeze (memory wait)
- flush  in  1  EX-resolved redirect; kills the ID instruction
- rs1, rs2  out  REG_AW  inst[15+:REG_AW], inst[20+:REG_AW], combinational
- re1, re2  out  1  source read enables, combinational
- stall  out  1  load-use stall request, combinational
- ex_fwd_a, ex_fwd_b  out  2  operand A/B select for instruction in EX: 0 regfile, 1 MEM result, 2 WB result, 3 held WB value
- ex_valid  out  1  EX holds a real instruction

## Operation
**Decode (opcode = inst[6:2], only when inst[1:0]==2'b11):**
- re1 = 1 for R, I_CAL, I_LOAD, S, B, JALR.
- re2 = 1 for R, S, B.
- we = 1 for R, I_CAL, I_LOAD, LUI, AUIPC, JAL, JALR.
- ld = 1 for I_LOAD.
- Any other opcode, or inst[1:0]!=2'b11: re1=re2=we=ld=0. Outputs are fully assigned; no latches.

**Shadow pipeline:**
- Entries s0 (EX), s1 (MEM), s2 (WB), each {v, rd, we, ld}.

**Match rule:**
- Source X matches stage k when reX && s_k.v && s_k.we && s_k.rd==rsX && rsX!=0.

**Load-use stall:**
- stall = HAZARD_EN && id_valid && !flush && (source 1 or 2 matches s0 with s0.ld).

**Forward code (per source; youngest match wins, s0 > s1 > s2):**
- s0 match → 1.
- s1 match → 2.
- s2 match → 3 if WB_BYPASS==0, else 0.
- No match → 0.
- Code forced to 0 when re of that source is 0.

**Advance (every cycle with hold==0):**
- s2<=s1 and s1<=s0.
- s0 <= decoded ID entry if id_valid && !stall && !flush; otherwise a bubble (v=0).
- ex_fwd_a/b and ex_valid load the same way: computed codes / 1 for a real instruction, 0 for a bubble.

**Hold:**
- hold==1 freezes all state.
- stall is still computed from the frozen state.

**Reset (rst_n==0 at clk edge):**
- All s_k.v=0; ex_fwd_a=ex_fwd_b=0; ex_valid=0.
- Reset overrides hold and flush.
- Reset mid-stall clears the stall next cycle, because no valid producers remain.

## Timing
- rs1/rs2/re1/re2/stall are combinational from id_inst and state, with zero latency.
- Forward codes are registered: they are valid in the cycle the consumer occupies EX.
- Load-use inserts exactly one bubble. The next cycle the load is in s1, giving code 2 with stall=0.
- flush and stall in the same cycle: flush wins (stall=0, bubble inserted).
- x0 destinations never match and never stall.
- Back-to-back writers to the same rd: the youngest stage is selected.

## Structure
- **Shared package `pipe_pkg`:**
  - opcode constants (R_TYPE, B_TYPE, I_CAL, I_LOAD, S_TYPE, LUI_TYPE, AUIPC_TYPE, JAL_TYPE, JALR_TYPE as 5-bit inst[6:2] values)
  - FWD_* code constants
  - the stage-entry struct.
- **Sub-module `inst_reg_decode`:** Combinational; maps id_inst to rs1, rs2, re1, re2, rd, we, ld.
- **Top level:** Holds the shadow pipeline, match/priority logic and output registers.

## Test plan
- **R-type dependency:**
  - Stimulus: add x5,x1,x2 then add x6,x5,x3 back-to-back.
  - Required: second instruction in EX sees ex_fwd_a=1, ex_fwd_b=0, stall never asserted.
- **Load-use:**
  - Stimulus: lw x7,0(x1) then add x8,x7,x7.
  - Required: stall=1 for one cycle; bubble in EX (ex_valid=0); then add in EX with ex_fwd_a=ex_fwd_b=2.
- **x0 and non-readers:**
  - Stimulus 1: lui x0,1 then add x9,x0,x0. Required: codes 0, no stall.
  - Stimulus 2: jal then lui reading rs fields 5/6 after a write to x5. Required: re1=re2=0, codes 0.
- **WB distance:**
  - Stimulus: producer to x4, two unrelated instructions, then consumer of x4.
  - Required: code 0 with WB_BYPASS=1; code 3 with WB_BYPASS=0.
- **Flush, hold, reset:**
  - flush during a load-use stall: stall=0 and a bubble is inserted.
  - hold=1 for 3 cycles: ex_fwd and ex_valid stay unchanged.
  - rst_n=0 with a valid pipeline: ex_valid=0 and codes 0 next cycle.
- **Illegal encoding:**
  - Stimulus: inst[1:0]=2'b01 or opcode 5'b11111.
  - Required: re1=re2=0; entry does not write (we=0) and produces no later match.
